// File: rtl/von_control_unit.sv
// Hardwired Moore control sequencer for the 8-bit accumulator CPU (fetch/decode/execute).
// Optional CU_HALT_EN: opcode 14 parks the sequencer in HALT until reset.
module von_control_unit (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] IR,
    output logic       load_AR,
    output logic       load_PC,
    output logic       load_DR,
    output logic       load_AC,
    output logic       load_IR,
    output logic       load_TR,
    output logic       clear_AR,
    output logic       clear_PC,
    output logic       clear_DR,
    output logic       clear_AC,
    output logic       clear_TR,
    output logic       inc_AR,
    output logic       inc_PC,
    output logic       inc_DR,
    output logic       inc_AC,
    output logic       inc_TR,
    output logic       memory_read,
    output logic       memory_write,
    output logic [2:0] bus_selectors,
    output logic       alu_enable,
    output logic [2:0] alu_mode
);
    typedef enum logic [2:0] {
        RST, F0, F1, D0, E0, E1
`ifdef CU_HALT_EN
        , HALT
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] opcode;
    logic       unused_addr;

    assign opcode      = IR[7:4];
    assign unused_addr = ^IR[3:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= RST;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        load_AR       = 1'b0;
        load_PC       = 1'b0;
        load_DR       = 1'b0;
        load_AC       = 1'b0;
        load_IR       = 1'b0;
        load_TR       = 1'b0;
        clear_AR      = 1'b0;
        clear_PC      = 1'b0;
        clear_DR      = 1'b0;
        clear_AC      = 1'b0;
        clear_TR      = 1'b0;
        inc_AR        = 1'b0;
        inc_PC        = 1'b0;
        inc_DR        = 1'b0;
        inc_AC        = 1'b0;
        inc_TR        = 1'b0;
        memory_read   = 1'b0;
        memory_write  = 1'b0;
        bus_selectors = 3'd0;
        alu_enable    = 1'b0;
        alu_mode      = 3'd0;
        case (state_q)
            RST: begin
                clear_AR = 1'b1;
                clear_PC = 1'b1;
                clear_DR = 1'b1;
                clear_AC = 1'b1;
                clear_TR = 1'b1;
                state_d  = F0;
            end
            F0: begin
                bus_selectors = 3'd2;
                load_AR       = 1'b1;
                state_d       = F1;
            end
            F1: begin
                memory_read   = 1'b1;
                bus_selectors = 3'd7;
                load_IR       = 1'b1;
                inc_PC        = 1'b1;
                state_d       = D0;
            end
            D0: begin
                bus_selectors = 3'd5;
                load_AR       = 1'b1;
                case (opcode)
                    4'd0, 4'd15: state_d = F0;
`ifdef CU_HALT_EN
                    4'd14:       state_d = HALT;
`else
                    4'd14:       state_d = F0;
`endif
                    default:     state_d = E0;
                endcase
            end
            E0: begin
                state_d = F0;
                case (opcode)
                    4'd1, 4'd2, 4'd3, 4'd9, 4'd10: begin
                        memory_read   = 1'b1;
                        bus_selectors = 3'd7;
                        load_DR       = 1'b1;
                        state_d       = E1;
                    end
                    4'd4: begin
                        bus_selectors = 3'd4;
                        memory_write  = 1'b1;
                    end
                    4'd5: begin
                        bus_selectors = 3'd1;
                        load_PC       = 1'b1;
                    end
                    4'd6: clear_AC = 1'b1;
                    4'd7: inc_AC   = 1'b1;
                    4'd8, 4'd11, 4'd12: begin
                        alu_enable = 1'b1;
                        load_AC    = 1'b1;
                        alu_mode   = (opcode == 4'd8)  ? 3'd5 :
                                     (opcode == 4'd11) ? 3'd6 : 3'd7;
                    end
                    4'd13: begin
                        memory_read   = 1'b1;
                        bus_selectors = 3'd7;
                        load_TR       = 1'b1;
                    end
                    default: ;
                endcase
            end
            E1: begin
                alu_enable = 1'b1;
                load_AC    = 1'b1;
                state_d    = F0;
                // Memory-reference opcodes map onto ALU modes AND/ADD/PASS/OR/XOR.
                case (opcode)
                    4'd1:    alu_mode = 3'd0;
                    4'd2:    alu_mode = 3'd1;
                    4'd3:    alu_mode = 3'd2;
                    4'd9:    alu_mode = 3'd3;
                    default: alu_mode = 3'd4;
                endcase
            end
`ifdef CU_HALT_EN
            HALT: state_d = HALT;
`endif
            default: state_d = RST;
        endcase
    end
endmodule

// File: tb/tb_von_control_unit.sv
// Scoreboarded random/directed bench for von_control_unit: expected per-cycle output
// patterns are queued by an instruction-level model and checked by a negedge monitor.
module tb_von_control_unit;
    typedef struct packed {
        logic       load_AR, load_PC, load_DR, load_AC, load_IR, load_TR;
        logic       clear_AR, clear_PC, clear_DR, clear_AC, clear_TR;
        logic       inc_AR, inc_PC, inc_DR, inc_AC, inc_TR;
        logic       memory_read, memory_write;
        logic [2:0] bus;
        logic       alu_enable;
        logic [2:0] alu_mode;
    } o_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] IR    = 8'h00;
    o_t         obs;
    o_t         q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         step  = 0;

    always #5 clock = ~clock;

    von_control_unit dut (
        .clock(clock), .reset(reset), .IR(IR),
        .load_AR(obs.load_AR), .load_PC(obs.load_PC), .load_DR(obs.load_DR),
        .load_AC(obs.load_AC), .load_IR(obs.load_IR), .load_TR(obs.load_TR),
        .clear_AR(obs.clear_AR), .clear_PC(obs.clear_PC), .clear_DR(obs.clear_DR),
        .clear_AC(obs.clear_AC), .clear_TR(obs.clear_TR),
        .inc_AR(obs.inc_AR), .inc_PC(obs.inc_PC), .inc_DR(obs.inc_DR),
        .inc_AC(obs.inc_AC), .inc_TR(obs.inc_TR),
        .memory_read(obs.memory_read), .memory_write(obs.memory_write),
        .bus_selectors(obs.bus), .alu_enable(obs.alu_enable), .alu_mode(obs.alu_mode)
    );

    function automatic o_t rst_pat();
        o_t e = '0;
        e.clear_AR = 1; e.clear_PC = 1; e.clear_DR = 1; e.clear_AC = 1; e.clear_TR = 1;
        return e;
    endfunction

    // Instruction-level model: pushes every cycle's expected outputs, returns cycle count.
    task automatic issue(input logic [7:0] ir, output int len);
        o_t e;
        logic [3:0] op = ir[7:4];
        e = '0; e.bus = 2; e.load_AR = 1; q.push_back(e);
        e = '0; e.bus = 7; e.memory_read = 1; e.load_IR = 1; e.inc_PC = 1; q.push_back(e);
        e = '0; e.bus = 5; e.load_AR = 1; q.push_back(e);
        len = 3;
        e = '0;
        case (op)
            1, 2, 3, 9, 10: begin
                e.memory_read = 1; e.bus = 7; e.load_DR = 1; q.push_back(e);
                e = '0; e.alu_enable = 1; e.load_AC = 1;
                e.alu_mode = (op == 1) ? 0 : (op == 2) ? 1 : (op == 3) ? 2 : (op == 9) ? 3 : 4;
                q.push_back(e);
                len = 5;
            end
            4:  begin e.bus = 4; e.memory_write = 1; q.push_back(e); len = 4; end
            5:  begin e.bus = 1; e.load_PC = 1; q.push_back(e); len = 4; end
            6:  begin e.clear_AC = 1; q.push_back(e); len = 4; end
            7:  begin e.inc_AC = 1; q.push_back(e); len = 4; end
            8:  begin e.alu_enable = 1; e.load_AC = 1; e.alu_mode = 5; q.push_back(e); len = 4; end
            11: begin e.alu_enable = 1; e.load_AC = 1; e.alu_mode = 6; q.push_back(e); len = 4; end
            12: begin e.alu_enable = 1; e.load_AC = 1; e.alu_mode = 7; q.push_back(e); len = 4; end
            13: begin e.memory_read = 1; e.bus = 7; e.load_TR = 1; q.push_back(e); len = 4; end
`ifdef CU_HALT_EN
            14: begin
                for (int i = 0; i < 12; i++) q.push_back('0);
                len = 15;
            end
`endif
            default: ;
        endcase
    endtask

    task automatic run(input logic [7:0] ir);
        int len;
        @(posedge clock); #1;
        issue(ir, len);
        IR = ir;
        repeat (len - 1) @(posedge clock);
    endtask

    initial begin : monitor
        o_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("FAIL step%0d IR=%h got=%h want=%h", step, IR, obs, e);
                end
                step++;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] dir[10];
        logic [7:0] r;
        dir = '{8'h25, 8'h4A, 8'h53, 8'h60, 8'h70, 8'h80, 8'hB0, 8'h00, 8'hF0, 8'hC7};
        for (int i = 0; i < 5; i++) q.push_back(rst_pat());
        repeat (5) @(negedge clock);
        #1 reset = 1'b0;
        foreach (dir[i]) run(dir[i]);

        // Async reset in E1 of LDA 0x31: outputs must flip before the next edge.
        begin
            int len;
            @(posedge clock); #1;
            issue(8'h31, len);
            void'(q.pop_back());
            IR = 8'h31;
            repeat (4) @(posedge clock);
            #1 reset = 1'b1;
            #1;
            n_cmp++;
            if (obs !== rst_pat()) begin
                n_bad++;
                $display("FAIL async_reset got=%h want=%h", obs, rst_pat());
            end
            q.push_back(rst_pat());
            q.push_back(rst_pat());
            repeat (2) @(negedge clock);
            #1 reset = 1'b0;
        end

        for (int i = 0; i < 60; i++) begin
            r = 8'($urandom);
`ifdef CU_HALT_EN
            if (r[7:4] == 4'd14) r[7:4] = 4'd7;
`endif
            run(r);
        end
        run(8'hE0);
`ifndef CU_HALT_EN
        run(8'h25);
`endif

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clock);
        if (q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d expected cycles left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
